// File: rtl/vx_csr_rmw_if.sv
// vx_csr_rmw_if: request/response bus between issue logic and the CSR RMW unit
interface vx_csr_rmw_if #(parameter int WID_W = 2);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [11:0]      req_addr;
  logic [WID_W-1:0] req_wid;
  logic [31:0]      req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_error;
  modport master (
    output req_valid, req_op, req_addr, req_wid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_error
  );
  modport slave (
    input  req_valid, req_op, req_addr, req_wid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/vx_csr_rmw_unit.sv
// vx_csr_rmw_unit: per-warp CSR bank with atomic RMW, flag accrual, shared counters and a registered response
module vx_csr_rmw_unit #(
  parameter int          NUM_WARPS    = 4,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [11:0] SCRATCH_BASE = 12'h7C0,
  parameter int          CTR_WIDTH    = 48,
  parameter int          COMMIT_W     = 3,
  parameter int          WID_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  vx_csr_rmw_if.slave         bus,
  input  logic                fflags_valid,
  input  logic [WID_W-1:0]    fflags_wid,
  input  logic [4:0]          fflags,
  input  logic [WID_W-1:0]    frm_wid,
  output logic [2:0]          frm,
  input  logic                commit_valid,
  input  logic [COMMIT_W-1:0] commit_size,
  input  logic                busy
);
  localparam int SI_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  logic [4:0]           ffl_q [NUM_WARPS];
  logic [2:0]           frm_q [NUM_WARPS];
  logic [31:0]          scr_q [NUM_WARPS][NUM_SCRATCH];
  logic [CTR_WIDTH-1:0] mcycle, minstret;
  logic [63:0]          mc64, mi64;
  logic [11:0]          a;
  logic [WID_W-1:0]     w;
  logic [SI_W-1:0]      si;
  logic [1:0]           op;
  logic [31:0]          d, old, new_v;
  logic hit_ffl, hit_frm, hit_fcsr, hit_mcl, hit_mch, hit_mil, hit_mih, hit_scr, hit, fire, wr;
  // Replace one 32-bit half of a counter; the high half is truncated to the counter width
  function automatic logic [CTR_WIDTH-1:0] ctr_wr(input logic [63:0] c, input logic lo, input logic [31:0] v);
    return CTR_WIDTH'(lo ? {c[63:32], v} : {v, c[31:0]});
  endfunction
  assign a        = bus.req_addr;
  assign w        = bus.req_wid;
  assign op       = bus.req_op;
  assign d        = bus.req_data;
  assign mc64     = 64'(mcycle);
  assign mi64     = 64'(minstret);
  assign hit_ffl  = a == 12'h001;
  assign hit_frm  = a == 12'h002;
  assign hit_fcsr = a == 12'h003;
  assign hit_mcl  = a == 12'hB00;
  assign hit_mch  = a == 12'hB80;
  assign hit_mil  = a == 12'hB02;
  assign hit_mih  = a == 12'hB82;
  assign hit_scr  = 12'(a - SCRATCH_BASE) < 12'(NUM_SCRATCH);
  assign si       = SI_W'(a - SCRATCH_BASE);
  assign hit      = hit_ffl | hit_frm | hit_fcsr | hit_mcl | hit_mch | hit_mil | hit_mih | hit_scr;
  assign bus.req_ready = ~bus.rsp_valid | bus.rsp_ready;
  assign fire     = bus.req_valid & bus.req_ready;
  assign old = hit_ffl  ? {27'b0, ffl_q[w]} :
               hit_frm  ? {29'b0, frm_q[w]} :
               hit_fcsr ? {24'b0, frm_q[w], ffl_q[w]} :
               hit_mcl  ? mc64[31:0] :
               hit_mch  ? mc64[63:32] :
               hit_mil  ? mi64[31:0] :
               hit_mih  ? mi64[63:32] :
               hit_scr  ? scr_q[w][si] : 32'b0;
  assign new_v = op == 2'd1 ? d : op == 2'd2 ? old | d : op == 2'd3 ? old & ~d : old;
  assign wr    = fire & hit & (op != 2'd0) & (op == 2'd1 | d != 32'b0);
  assign frm   = frm_q[frm_wid];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        ffl_q[i] <= '0;
        frm_q[i] <= '0;
        for (int j = 0; j < NUM_SCRATCH; j++) scr_q[i][j] <= '0;
      end
      mcycle        <= '0;
      minstret      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      // Accrued FPU flags are OR-ed on top of any same-cycle CSR write so none are lost
      for (int i = 0; i < NUM_WARPS; i++) begin
        ffl_q[i] <= ((wr && w == WID_W'(i) && (hit_ffl || hit_fcsr)) ? new_v[4:0] : ffl_q[i])
                  | ((fflags_valid && fflags_wid == WID_W'(i)) ? fflags : 5'b0);
        if (wr && w == WID_W'(i) && (hit_frm || hit_fcsr)) frm_q[i] <= hit_fcsr ? new_v[7:5] : new_v[2:0];
      end
      if (wr && hit_scr) scr_q[w][si] <= new_v;
      mcycle   <= (wr && (hit_mcl || hit_mch)) ? ctr_wr(mc64, hit_mcl, new_v) : mcycle + CTR_WIDTH'(busy);
      minstret <= (wr && (hit_mil || hit_mih)) ? ctr_wr(mi64, hit_mil, new_v)
                : minstret + (commit_valid ? CTR_WIDTH'(commit_size) : '0);
      if (fire) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= old;
        bus.rsp_error <= ~hit;
      end else if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
  end
endmodule
